// File: rtl/dfr_pkg.sv
// dfr_pkg: shared state type, MM wait constant and run-length check for the DFR run sequencer.
package dfr_pkg;

    typedef enum logic [2:0] {
        IDLE, RES_RST, RES_RUN, RES_DRAIN, MM_RST, MM_START, MM_WAIT, DONE
    } dfr_seq_state_t;

    localparam int unsigned DFR_SEQ_MIN_MM_WAIT = 2;

    // A run is legal when it has at least one word and fits the address space exactly or less.
    function automatic logic dfr_len_ok(input logic [63:0] total, input int unsigned addr_width);
        return (total != 64'd0) && (total <= (64'd1 << addr_width));
    endfunction

endpackage

// File: rtl/dfr_seq_delay_pipe.sv
// dfr_seq_delay_pipe: flushable valid+address shift register aligning history writes with reservoir output.
module dfr_seq_delay_pipe #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  pending_o
);

    // Every stage except the output one; empty means the current output is the final write.
    localparam logic [DEPTH-1:0] PEND_MASK = DEPTH'((64'd1 << (DEPTH - 1)) - 64'd1);

    logic [DEPTH-1:0]                 v_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] a_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            a_q <= '0;
        end else begin
            v_q[0] <= valid_i && !flush_i;
            a_q[0] <= addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1] && !flush_i;
                a_q[i] <= a_q[i-1];
            end
        end
    end

    assign valid_o   = v_q[DEPTH-1];
    assign addr_o    = a_q[DEPTH-1];
    assign pending_o = |(v_q & PEND_MASK);

endmodule

// File: rtl/dfr_core_sequencer.sv
// dfr_core_sequencer: run sequencer driving reservoir, history commit and output-layer multiply.
// Optional DFR_SEQ_PERF_CNT_EN adds a 32-bit busy-cycle counter output cycle_count.
import dfr_pkg::*;

module dfr_core_sequencer #(
    parameter int ADDR_WIDTH    = 14,
    parameter int VIRTUAL_NODES = 10,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int RES_LATENCY   = 2
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic                    start,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] num_samples,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   progress,
    output logic [ADDR_WIDTH-1:0]   in_addr,
    output logic                    reservoir_en,
    output logic                    reservoir_rst,
    output logic [ADDR_WIDTH-1:0]   hist_addr,
    output logic                    hist_wen,
    output logic                    mm_rst,
    output logic                    mm_start,
    input  logic                    mm_busy
`ifdef DFR_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]             cycle_count
`endif
);

    localparam int PROD_W = SAMPLE_WIDTH + $clog2(VIRTUAL_NODES + 1);

    dfr_seq_state_t        state_q, state_d;
    logic                  busy_q, done_q, error_q, res_en_q, res_rst_q, mm_rst_q, mm_start_q;
    logic [ADDR_WIDTH-1:0] progress_q, in_addr_q, last_q;
    logic [1:0]            wait_q;
    logic [PROD_W-1:0]     total;
    logic                  len_ok, run_busy, go, abort_run, last_issue, wait_ok, pipe_pending;

    assign total      = PROD_W'(num_samples) * PROD_W'(VIRTUAL_NODES);
    assign len_ok     = dfr_len_ok(64'(total), ADDR_WIDTH);
    assign run_busy   = !(state_q inside {IDLE, DONE});
    assign go         = start && !abort && !run_busy;
    assign abort_run  = abort && run_busy;
    assign last_issue = in_addr_q == last_q;
    assign wait_ok    = 32'(wait_q) >= DFR_SEQ_MIN_MM_WAIT - 1;

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: state_d = go ? (len_ok ? RES_RST : DONE) : state_q;
                RES_RST:    state_d = RES_RUN;
                RES_RUN:    state_d = last_issue ? RES_DRAIN : RES_RUN;
                RES_DRAIN:  state_d = pipe_pending ? RES_DRAIN : MM_RST;
                MM_RST:     state_d = MM_START;
                MM_START:   state_d = MM_WAIT;
                MM_WAIT:    state_d = (wait_ok && !mm_busy) ? DONE : MM_WAIT;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            res_en_q   <= 1'b0;
            res_rst_q  <= 1'b0;
            mm_rst_q   <= 1'b0;
            mm_start_q <= 1'b0;
            progress_q <= '0;
            in_addr_q  <= '0;
            last_q     <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= !(state_d inside {IDLE, DONE});
            res_rst_q  <= state_d == RES_RST;
            res_en_q   <= state_d inside {RES_RUN, RES_DRAIN};
            mm_rst_q   <= (state_d == MM_RST) || abort_run;
            mm_start_q <= state_d == MM_START;
            done_q     <= go ? 1'b0 : (done_q || state_q == DONE);
            error_q    <= go ? !len_ok : error_q;
            last_q     <= go ? ADDR_WIDTH'(total - 1'b1) : last_q;
            // Holding at the last address lets a full 2^ADDR_WIDTH run end on all-ones without wrapping.
            in_addr_q  <= go ? '0 : (state_q == RES_RUN && !last_issue && !abort) ? in_addr_q + 1'b1 : in_addr_q;
            progress_q <= go ? '0 : (hist_wen && !(&progress_q)) ? progress_q + 1'b1 : progress_q;
            wait_q     <= (state_q != MM_WAIT) ? '0 : wait_ok ? wait_q : wait_q + 1'b1;
        end
    end

    dfr_seq_delay_pipe #(
        .DEPTH      (RES_LATENCY),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pipe (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .flush_i   (abort_run),
        .valid_i   (state_q == RES_RUN),
        .addr_i    (in_addr_q),
        .valid_o   (hist_wen),
        .addr_o    (hist_addr),
        .pending_o (pipe_pending)
    );

`ifdef DFR_SEQ_PERF_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= go ? '0 : (busy_q && !(&cyc_q)) ? cyc_q + 1'b1 : cyc_q;
        end
    end

    assign cycle_count = cyc_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign progress      = progress_q;
    assign in_addr       = in_addr_q;
    assign reservoir_en  = res_en_q;
    assign reservoir_rst = res_rst_q;
    assign mm_rst        = mm_rst_q;
    assign mm_start      = mm_start_q;

endmodule

// File: tb/tb_dfr_core_sequencer.sv
// tb_dfr_core_sequencer: scoreboard bench for the DFR run sequencer (ADDR_WIDTH=6, 10 nodes, latency 2).
module tb_dfr_core_sequencer;
    localparam int AW = 6, VN = 10, SW = 16, LAT = 2;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, mm_busy = 1'b0;
    logic [SW-1:0] num_samples = '0;
    logic          busy, done, error, reservoir_en, reservoir_rst, hist_wen, mm_rst, mm_start;
    logic [AW-1:0] progress, in_addr, hist_addr;
`ifdef DFR_SEQ_PERF_CNT_EN
    logic [31:0]   cycle_count;
`endif

    always #5 clk = ~clk;

    dfr_core_sequencer #(
        .ADDR_WIDTH(AW), .VIRTUAL_NODES(VN), .SAMPLE_WIDTH(SW), .RES_LATENCY(LAT)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .num_samples(num_samples), .busy(busy), .done(done), .error(error),
        .progress(progress), .in_addr(in_addr), .reservoir_en(reservoir_en),
        .reservoir_rst(reservoir_rst), .hist_addr(hist_addr), .hist_wen(hist_wen),
        .mm_rst(mm_rst), .mm_start(mm_start), .mm_busy(mm_busy)
`ifdef DFR_SEQ_PERF_CNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    int            n_checks = 0, n_err = 0;
    int            hist_cnt = 0, mm_start_cnt = 0, mm_rst_cnt = 0, busy_cnt = 0, cyc = 0, mm_start_cyc = 0;
    bit            mm_model = 1'b1;
    logic [AW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every history write must match the next expected address.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (hist_wen) begin
            hist_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d with nothing expected", hist_addr);
            end else begin
                check("hist_addr", 64'(hist_addr), 64'(exp_q.pop_front()));
            end
        end
        if (mm_start) begin
            mm_start_cnt++;
            mm_start_cyc = cyc;
        end
        if (mm_rst) mm_rst_cnt++;
        if (busy) busy_cnt++;
    end

    // Multiplier model: raises busy right after mm_start for five cycles.
    initial forever begin
        @(negedge clk);
        if (mm_start && mm_model) begin
            mm_busy = 1'b1;
            repeat (5) @(negedge clk);
            mm_busy = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_counts();
        hist_cnt = 0; mm_start_cnt = 0; mm_rst_cnt = 0; busy_cnt = 0;
    endtask

    task automatic expect_run(input int total);
        for (int i = 0; i < total; i++) exp_q.push_back(AW'(i));
    endtask

    task automatic issue(input int ns);
        @(posedge clk); #1;
        start = 1'b1;
        num_samples = SW'(ns);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: done=0 after %0d cycles", name, k);
        end
        #1;
    endtask

    initial begin
        int w, k, h, done_cyc;
        @(negedge clk);
        check("reset_flags", {busy, done, error, reservoir_en, reservoir_rst, hist_wen, mm_rst, mm_start}, 0);
        check("reset_progress", 64'(progress), 0);
        check("reset_addrs", {in_addr, hist_addr}, 0);
        #3 rst_n = 1'b1;

        // Nominal run: 3 samples x 10 nodes
        clear_counts();
        expect_run(30);
        issue(3);
        @(negedge clk);
        check("n1_busy_rst_en", {busy, reservoir_rst, reservoir_en}, 3'b110);
        @(negedge clk);
        check("n2_en_rst", {reservoir_en, reservoir_rst}, 2'b10);
        check("n2_in_addr", 64'(in_addr), 0);
        @(negedge clk);
        check("n3_in_addr", 64'(in_addr), 1);
        check("n3_no_write", 64'(hist_wen), 0);
        @(negedge clk);
        check("n4_first_write", 64'(hist_wen), 1);
        wait_done("run30");
        check("run30_writes", hist_cnt, 30);
        check("run30_progress", 64'(progress), 30);
        check("run30_mm_start", mm_start_cnt, 1);
        check("run30_mm_rst", mm_rst_cnt, 1);
        check("run30_err_busy", {error, busy}, 0);
        check("run30_queue", exp_q.size(), 0);

        // Zero samples: length error, done one cycle later, no activity
        clear_counts();
        issue(0);
        @(negedge clk);
        check("zero_flags_n1", {error, done, busy}, 3'b100);
        @(negedge clk);
        check("zero_done_n2", 64'(done), 1);
        repeat (5) @(negedge clk);
        #1;
        check("zero_activity", {hist_cnt[7:0], mm_start_cnt[7:0], mm_rst_cnt[7:0]}, 0);

        // 7 samples = 70 words > 64: error
        clear_counts();
        issue(7);
        @(negedge clk);
        check("over_error", {error, busy}, 2'b10);
        repeat (4) @(negedge clk);
        #1;
        check("over_writes", hist_cnt, 0);
        check("over_done", 64'(done), 1);

        // 6 samples = 60 words: error cleared
        clear_counts();
        expect_run(60);
        issue(6);
        @(negedge clk);
        check("s6_cleared", {error, done, busy}, 3'b001);
        wait_done("run60");
        check("run60_writes", hist_cnt, 60);
        check("run60_progress", 64'(progress), 60);
        check("run60_queue", exp_q.size(), 0);

        // Abort right after the 12th write
        clear_counts();
        expect_run(30);
        issue(3);
        w = 0; k = 0;
        while (w < 12 && k < 200) begin
            @(negedge clk);
            k++;
            if (hist_wen) w++;
        end
        check("abort_reach_12", w, 12);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_next", {busy, hist_wen, mm_rst, done}, 4'b0010);
        check("abort_progress", 64'(progress), 12);
        repeat (6) @(negedge clk);
        #1;
        check("abort_writes", hist_cnt, 12);
        check("abort_mm_rst", mm_rst_cnt, 1);
        check("abort_mm_start", mm_start_cnt, 0);
        check("abort_left", exp_q.size(), 18);
        check("abort_hold", {done, error, progress}, {2'b00, 6'd12});
        exp_q.delete();

        // start pulsed mid-run is ignored
        clear_counts();
        expect_run(20);
        issue(2);
        repeat (5) @(negedge clk);
        start = 1'b1;
        num_samples = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start");
        check("ignore_writes", hist_cnt, 20);
        check("ignore_mm_start", mm_start_cnt, 1);
        check("ignore_progress", 64'(progress), 20);

        // start from DONE begins a new run with done cleared
        clear_counts();
        expect_run(10);
        issue(1);
        @(negedge clk);
        check("restart_done_clr", {done, busy}, 2'b01);
        wait_done("restart");
        check("restart_writes", hist_cnt, 10);
        check("restart_progress", 64'(progress), 10);

        // start together with abort while idle/done: abort wins
        clear_counts();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; num_samples = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("sa_no_start", {busy, reservoir_rst}, 0);
        repeat (4) @(negedge clk);
        #1;
        check("sa_writes", hist_cnt, 0);
        check("sa_done_sticky", 64'(done), 1);

        // mm_busy held low: done must still wait after mm_start
        mm_model = 1'b0;
        clear_counts();
        expect_run(10);
        issue(1);
        wait_done("mm_low");
        done_cyc = cyc;
        check("mm_low_min_wait", 64'(done_cyc - mm_start_cyc >= 2), 1);
        check("mm_low_writes", hist_cnt, 10);
        check("mm_low_mm_start", mm_start_cnt, 1);
`ifdef DFR_SEQ_PERF_CNT_EN
        check("cycle_count", 64'(cycle_count), 64'(busy_cnt));
`endif

        // Asynchronous reset mid-run
        clear_counts();
        expect_run(30);
        issue(3);
        repeat (8) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {busy, hist_wen, reservoir_en, done}, 0);
        check("arst_progress", 64'(progress), 0);
        h = hist_cnt;
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("arst_no_writes", hist_cnt, h);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
